shift_sub_div: RTL

Iterative restoring shift-subtract divider for unsigned operands: the inverse of the team's shift-add multiplier, and it sits beside it in the same arithmetic datapath. A one-cycle `start` launches a division, and the block spends WIDTH cycles producing one quotient bit per cycle. It then pulses `done` with quotient and remainder, which stay registered until the next result. A divisor of zero is detected up front and flagged rather than iterated.

---
 rtl/arith_pkg.sv | 17 +
 rtl/shift_sub_div_if.sv | 28 ++
 rtl/div_step.sv | 27 ++
 rtl/shift_sub_div.sv | 118 +++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | arith_pkg : types and constants shared by the arithmetic blocks |
// | Revision  : 1.0                                                 |
// +-----------------------------------------------------------------+
package arith_pkg;

  localparam int ARITH_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage : arith_pkg
`default_nettype wire

// File: rtl/shift_sub_div_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | shift_sub_div_if : request/result bundle of the divider          |
// | Revision         : 1.0                                           |
// +-----------------------------------------------------------------+
interface shift_sub_div_if #(
  parameter int WIDTH = arith_pkg::ARITH_W
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface : shift_sub_div_if
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | div_step : one combinational restoring-division iteration        |
// | Revision : 1.0                                                   |
// +-----------------------------------------------------------------+
module div_step #(
  parameter int WIDTH = 4
) (
  input  wire logic [WIDTH-1:0] i_rem,
  input  wire logic             i_q_msb,
  input  wire logic [WIDTH-1:0] i_divisor,
  output logic      [WIDTH:0]   o_rem,
  output logic                  o_q_bit
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_trial;

  assign w_shift = {i_rem, i_q_msb};
  assign w_trial = w_shift - {1'b0, i_divisor};

  // A borrow out of the trial subtract means the divisor did not fit: restore.
  assign o_q_bit = ~w_trial[WIDTH];
  assign o_rem   = w_trial[WIDTH] ? w_shift : w_trial;

endmodule : div_step
`default_nettype wire

// File: rtl/shift_sub_div.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | shift_sub_div : iterative unsigned restoring divider, 1 bit/cycle|
// | Revision      : 1.0                                              |
// +-----------------------------------------------------------------+
module shift_sub_div
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_W
) (
  input wire logic          clk,
  input wire logic          rst,
  shift_sub_div_if.slave    bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  div_state_t       r_state;
  div_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remd;
  logic             r_dbz;

  logic [WIDTH:0]   w_rem_nxt;
  logic             w_q_bit;
  logic             w_last;
  logic             w_unused_rem_msb;

  // The partial remainder stays below the divisor, so its top bit is always 0.
  assign w_unused_rem_msb = r_rem[WIDTH];
  assign w_last           = (r_cnt == CNT_W'(WIDTH - 1));

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem[WIDTH-1:0]),
    .i_q_msb   (r_q[WIDTH-1]),
    .i_divisor (r_dvs),
    .o_rem     (w_rem_nxt),
    .o_q_bit   (w_q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = (bus.divisor != '0) ? CALC : DONE;
        end
      end
      CALC: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= '0;
      r_rem  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_quot <= '0;
      r_remd <= '0;
      r_dbz  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            if (bus.divisor != '0) begin
              r_dvs <= bus.divisor;
              r_q   <= bus.dividend;
              r_rem <= '0;
              r_cnt <= '0;
              r_dbz <= 1'b0;
            end else begin
              r_quot <= '1;
              r_remd <= bus.dividend;
              r_dbz  <= 1'b1;
            end
          end
        end
        CALC: begin
          r_q   <= {r_q[WIDTH-2:0], w_q_bit};
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_quot <= {r_q[WIDTH-2:0], w_q_bit};
            r_remd <= w_rem_nxt[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (r_state != IDLE);
  assign bus.done        = (r_state == DONE);
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_remd;
  assign bus.div_by_zero = r_dbz;

endmodule : shift_sub_div
`default_nettype wire
